// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone B4 slave among
// several pipelined masters, with outstanding-request tracking and drain.
module wb_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                  i_wb_clk,
    input  logic                                  i_wb_rst,
    input  logic [NUM_MASTERS-1:0]                i_m_cyc,
    input  logic [NUM_MASTERS-1:0]                i_m_stb,
    input  logic [NUM_MASTERS-1:0]                i_m_we,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   i_m_sel,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     i_m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     i_m_data,
    output logic [DATA_WIDTH-1:0]                 o_m_data,
    output logic [NUM_MASTERS-1:0]                o_m_ack,
    output logic [NUM_MASTERS-1:0]                o_m_stall,
    output logic                                  o_s_cyc,
    output logic                                  o_s_stb,
    output logic                                  o_s_we,
    output logic [DATA_WIDTH/8-1:0]               o_s_sel,
    output logic [ADDR_WIDTH-1:0]                 o_s_addr,
    output logic [DATA_WIDTH-1:0]                 o_s_data,
    input  logic [DATA_WIDTH-1:0]                 i_s_data,
    input  logic                                  i_s_ack,
    input  logic                                  i_s_stall
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [GW-1:0]   r_g;
    logic [GW-1:0]   r_last;
    logic [GW-1:0]   w_win;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_found;
    logic            w_cyc_g;
    logic            w_stb_g;
    logic            w_stb;
    logic            w_acc;
    logic            w_full;
    logic            w_ack_ok;
    int              w_idx;

    assign w_full   = (r_cnt == MAXC);
    assign w_ack_ok = i_s_ack && (r_cnt != '0);
    assign o_m_data = i_s_data;

    // First requester after the previous owner, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last;
        w_idx   = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            w_idx = int'(r_last) + i;
            if (w_idx >= NUM_MASTERS)
                w_idx = w_idx - NUM_MASTERS;
            if (!w_found && i_m_cyc[w_idx]) begin
                w_found = 1'b1;
                w_win   = GW'(w_idx);
            end
        end
    end

    always_comb begin
        w_cyc_g  = 1'b0;
        w_stb_g  = 1'b0;
        o_s_we   = 1'b0;
        o_s_sel  = '0;
        o_s_addr = '0;
        o_s_data = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (r_g == GW'(k)) begin
                w_cyc_g  = i_m_cyc[k];
                w_stb_g  = i_m_stb[k];
                o_s_we   = i_m_we[k];
                o_s_sel  = i_m_sel[k*SW +: SW];
                o_s_addr = i_m_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                o_s_data = i_m_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        w_stb     = 1'b0;
        w_acc     = 1'b0;
        o_s_cyc   = 1'b0;
        o_s_stb   = 1'b0;
        o_m_ack   = '0;
        o_m_stall = '1;
        unique case (r_state)
            IDLE: begin
                if (w_found)
                    w_next = BUSY;
            end
            BUSY: begin
                // CYC stays up while requests are still in flight.
                o_s_cyc   = w_cyc_g | (r_cnt != '0);
                w_stb     = w_cyc_g & w_stb_g & ~w_full;
                o_s_stb   = w_stb;
                w_acc     = w_stb & ~i_s_stall;
                w_cnt_nxt = r_cnt + CW'(w_acc) - CW'(w_ack_ok);
                for (int k = 0; k < NUM_MASTERS; k++) begin
                    if (r_g == GW'(k)) begin
                        o_m_stall[k] = i_s_stall | w_full;
                        o_m_ack[k]   = w_ack_ok;
                    end
                end
                if (!w_cyc_g)
                    w_next = (w_cnt_nxt == '0) ? IDLE : DRAIN;
            end
            DRAIN: begin
                o_s_cyc   = 1'b1;
                w_cnt_nxt = r_cnt - CW'(w_ack_ok);
                if (w_cnt_nxt == '0)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_state <= IDLE;
            r_g     <= '0;
            r_last  <= GW'(NUM_MASTERS - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            if (r_state == IDLE && w_found) begin
                r_g    <= w_win;
                r_last <= w_win;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic,
// every cycle compared with a transaction-level reference model.
module tb_wb_arbiter;
  localparam int NM = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NM-1:0] m_cyc = '0;
  logic [NM-1:0] m_stb = '0;
  logic [NM-1:0] m_we = '0;
  logic [NM*SW-1:0] m_sel = '0;
  logic [NM*AW-1:0] m_addr = '0;
  logic [NM*DW-1:0] m_wdat = '0;
  logic [DW-1:0] m_rdat;
  logic [NM-1:0] m_ack;
  logic [NM-1:0] m_stall;
  logic s_cyc, s_stb, s_we;
  logic [SW-1:0] s_sel;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdat;
  logic [DW-1:0] s_rdat = '0;
  logic s_ack = 1'b0;
  logic s_stall = 1'b0;

  wb_arbiter #(
    .NUM_MASTERS(NM), .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .i_wb_clk(clk), .i_wb_rst(rst),
    .i_m_cyc(m_cyc), .i_m_stb(m_stb),
    .i_m_we(m_we), .i_m_sel(m_sel),
    .i_m_addr(m_addr), .i_m_data(m_wdat),
    .o_m_data(m_rdat), .o_m_ack(m_ack),
    .o_m_stall(m_stall),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb),
    .o_s_we(s_we), .o_s_sel(s_sel),
    .o_s_addr(s_addr), .o_s_data(s_wdat),
    .i_s_data(s_rdat), .i_s_ack(s_ack),
    .i_s_stall(s_stall)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: owner < 0 means nobody holds the bus.
  int m_owner = -1;
  bit m_drain = 1'b0;
  int m_last = NM - 1;
  int m_cnt = 0;

  int n_acc = 0;
  int n_fwd = 0;
  int n_low = 0;
  int n_ackm [NM];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic int rr_pick(int last);
    for (int i = 1; i <= NM; i++) begin
      int k;
      k = (last + i) % NM;
      if (m_cyc[k]) return k;
    end
    return -1;
  endfunction

  task automatic set_m(input int k, input bit cyc,
                       input bit stb, input bit we,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    m_cyc[k] = cyc;
    m_stb[k] = stb;
    m_we[k] = we;
    m_sel[k*SW +: SW] = '1;
    m_addr[k*AW +: AW] = a;
    m_wdat[k*DW +: DW] = d;
  endtask

  task automatic cycle();
    logic e_cyc, e_stb;
    logic [NM-1:0] e_ack, e_stall;
    int acc, dec, ncnt, g;
    @(negedge clk);
    e_cyc = 1'b0;
    e_stb = 1'b0;
    e_ack = '0;
    e_stall = '1;
    acc = 0;
    dec = 0;
    ncnt = m_cnt;
    g = m_owner;
    if (m_drain) begin
      e_cyc = 1'b1;
      dec = (s_ack && m_cnt > 0) ? 1 : 0;
      ncnt = m_cnt - dec;
    end else if (g >= 0) begin
      e_cyc = m_cyc[g] || (m_cnt > 0);
      e_stb = m_cyc[g] && m_stb[g] && (m_cnt < MAXO);
      e_stall[g] = s_stall || (m_cnt == MAXO);
      e_ack[g] = s_ack && (m_cnt > 0);
      acc = (e_stb && !s_stall) ? 1 : 0;
      dec = (s_ack && m_cnt > 0) ? 1 : 0;
      ncnt = m_cnt + acc - dec;
      chk("s_addr", s_addr, m_addr[g*AW +: AW]);
      chk("s_wdat", s_wdat, m_wdat[g*DW +: DW]);
      chk("s_we", s_we, m_we[g]);
      chk("s_sel", s_sel, m_sel[g*SW +: SW]);
    end
    chk("s_cyc", s_cyc, e_cyc);
    chk("s_stb", s_stb, e_stb);
    chk("m_ack", m_ack, e_ack);
    chk("m_stall", m_stall, e_stall);
    if (|e_ack) chk("m_rdat", m_rdat, s_rdat);
    n_acc += (s_stb && !s_stall) ? 1 : 0;
    n_fwd += (|m_ack) ? 1 : 0;
    n_low += s_cyc ? 0 : 1;
    for (int k = 0; k < NM; k++) n_ackm[k] += m_ack[k];
    if (rst) begin
      m_owner = -1;
      m_drain = 1'b0;
      m_last = NM - 1;
      m_cnt = 0;
    end else if (m_drain) begin
      m_cnt = ncnt;
      if (ncnt == 0) m_drain = 1'b0;
    end else if (g >= 0) begin
      m_cnt = ncnt;
      if (!m_cyc[g]) begin
        m_owner = -1;
        m_drain = (ncnt != 0);
      end
    end else if (|m_cyc) begin
      m_owner = rr_pick(m_last);
      m_last = m_owner;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    // 1: idle after reset
    do_reset();
    repeat (10) cycle();
    chk("t1_stall", m_stall, {NM{1'b1}});

    // 2: three pipelined reads from master 1
    do_reset();
    for (int k = 0; k < NM; k++) n_ackm[k] = 0;
    set_m(1, 1, 1, 0, 'h100, 0);
    cycle();
    chk("t2_grant", s_cyc, 1);
    cycle();
    set_m(1, 1, 1, 0, 'h104, 0);
    cycle();
    set_m(1, 1, 1, 0, 'h108, 0);
    s_ack = 1'b1;
    s_rdat = 'hA1;
    cycle();
    set_m(1, 1, 0, 0, 'h108, 0);
    s_rdat = 'hA2;
    cycle();
    s_rdat = 'hA3;
    cycle();
    s_ack = 1'b0;
    set_m(1, 0, 0, 0, 0, 0);
    repeat (2) cycle();
    chk("t2_acks_m1", n_ackm[1], 3);
    chk("t2_acks_m0", n_ackm[0], 0);

    // 3: simultaneous requests, then handover
    do_reset();
    set_m(0, 1, 0, 0, 'h10, 0);
    set_m(1, 1, 0, 0, 'h20, 0);
    cycle();
    chk("t3_first", m_stall, 3'b110);
    repeat (2) cycle();
    set_m(0, 0, 0, 0, 0, 0);
    n_low = 0;
    repeat (4) cycle();
    chk("t3_second", m_stall, 3'b101);
    chk("t3_gap", n_low >= 1, 1);
    set_m(1, 0, 0, 0, 0, 0);
    repeat (3) cycle();

    // 4: outstanding limit with acks withheld
    do_reset();
    set_m(0, 1, 1, 1, 'h200, 'hDEAD);
    cycle();
    n_acc = 0;
    repeat (8) cycle();
    chk("t4_accepts", n_acc, MAXO);
    chk("t4_stall", m_stall[0], 1);
    chk("t4_stb", s_stb, 0);
    s_ack = 1'b1;
    cycle();
    s_ack = 1'b0;
    n_acc = 0;
    repeat (4) cycle();
    chk("t4_reaccept", n_acc, 1);

    // 6a: accept and ack together at three outstanding
    s_ack = 1'b1;
    cycle();
    n_acc = 0;
    cycle();
    chk("t6_both_acc", n_acc, 1);
    s_ack = 1'b0;
    n_acc = 0;
    repeat (3) cycle();
    chk("t6_hold3", n_acc, 1);

    // 5: abort with two outstanding
    set_m(0, 1, 0, 1, 'h200, 'hDEAD);
    s_ack = 1'b1;
    repeat (2) cycle();
    s_ack = 1'b0;
    set_m(0, 0, 0, 0, 0, 0);
    cycle();
    chk("t5_drain_cyc", s_cyc, 1);
    n_fwd = 0;
    s_ack = 1'b1;
    repeat (2) cycle();
    chk("t5_swallow", n_fwd, 0);
    chk("t5_idle", s_cyc, 0);
    cycle();
    s_ack = 1'b0;
    cycle();
    chk("t5_stray", n_fwd, 0);
    chk("t5_stray_cyc", s_cyc, 0);

    // 6b: reset while busy
    set_m(2, 1, 1, 0, 'h300, 0);
    repeat (3) cycle();
    do_reset();
    chk("t6_rst_cyc", s_cyc, 0);
    chk("t6_rst_stall", m_stall, {NM{1'b1}});
    set_m(2, 0, 0, 0, 0, 0);
    repeat (2) cycle();

    // random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < NM; k++) begin
        bit c;
        c = m_cyc[k];
        if (c && $urandom_range(0, 11) == 0) c = 1'b0;
        else if (!c && $urandom_range(0, 5) == 0) c = 1'b1;
        set_m(k, c, c & $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom, $urandom);
        m_sel[k*SW +: SW] = SW'($urandom);
      end
      s_stall = ($urandom_range(0, 3) == 0);
      s_ack = ($urandom_range(0, 2) == 0);
      s_rdat = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
